// File: rtl/xadc_drp_sched_if.sv
// rtl/xadc_drp_sched_if.sv - signal bundle between the DRP scheduler, the XADC wrapper, the host and result consumers
interface xadc_drp_sched_if;
  logic        eoc;
  logic [4:0]  channel;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_err;
  logic [15:0] aux_a_data;
  logic [15:0] aux_b_data;
  logic        sample_vld;
  logic        ovr;

  modport master (
    input  eoc, channel, dout, drdy, host_req, host_we, host_addr, host_wdata,
    output den, dwe, daddr, di, host_ack, host_rdata, host_err,
           aux_a_data, aux_b_data, sample_vld, ovr
  );

  modport slave (
    output eoc, channel, dout, drdy, host_req, host_we, host_addr, host_wdata,
    input  den, dwe, daddr, di, host_ack, host_rdata, host_err,
           aux_a_data, aux_b_data, sample_vld, ovr
  );
endinterface

// File: rtl/xadc_drp_sched.sv
// rtl/xadc_drp_sched.sv - XADC DRP owner arbitrating EOC auto-poll reads against host accesses
// Optional DRDY timeout abort: define XADC_DRP_TIMEOUT_EN.
module xadc_drp_sched #(
  parameter int unsigned STARVE_LIM  = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [6:0]  AUX_A_ADDR  = 7'h13,
  parameter logic [6:0]  AUX_B_ADDR  = 7'h12
) (
  input  logic             dclk,
  input  logic             reset_n,
  xadc_drp_sched_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

  if (STARVE_LIM > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("xadc_drp_sched: parameter out of range");
  end

  state_t      state, state_nxt;
  logic        poll_pend;
  logic [6:0]  poll_addr;
  logic        ovr;
  logic [7:0]  starve_cnt;
  logic        cur_host;
  logic        cur_we;
  logic [6:0]  cur_addr;
  logic [15:0] cur_wdata;
  logic        grant_poll, grant_host;
  logic        host_wins;
  logic        drp_done, drp_abort;
  logic        timeout_hit;
  logic        den, dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [15:0] aux_a, aux_b;
  logic        sample_vld;

  assign host_wins = bus.host_req && (starve_cnt == STARVE_MAX);
  assign drp_done  = (state == S_WAIT) && bus.drdy;
  assign drp_abort = (state == S_WAIT) && !bus.drdy && timeout_hit;

  always_comb begin
    state_nxt  = state;
    grant_poll = 1'b0;
    grant_host = 1'b0;
    den        = 1'b0;
    dwe        = 1'b0;
    daddr      = 7'h00;
    di         = 16'h0000;
    case (state)
      S_IDLE: begin
        if (poll_pend && !host_wins) begin
          grant_poll = 1'b1;
          state_nxt  = S_ISSUE;
        end else if (bus.host_req) begin
          grant_host = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        den       = 1'b1;
        dwe       = cur_we;
        daddr     = cur_addr;
        di        = cur_wdata;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (drp_done || drp_abort) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur_host  <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= 7'h00;
      cur_wdata <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (grant_poll) begin
        cur_host  <= 1'b0;
        cur_we    <= 1'b0;
        cur_addr  <= poll_addr;
        cur_wdata <= 16'h0000;
      end else if (grant_host) begin
        cur_host  <= 1'b1;
        cur_we    <= bus.host_we;
        cur_addr  <= bus.host_addr;
        cur_wdata <= bus.host_wdata;
      end
    end
  end

  // A fresh EOC in the grant cycle must survive the clear, hence eoc first.
  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      poll_pend  <= 1'b0;
      poll_addr  <= 7'h00;
      ovr        <= 1'b0;
      starve_cnt <= 8'h00;
    end else begin
      if (bus.eoc) begin
        poll_pend <= 1'b1;
        poll_addr <= {2'b00, bus.channel};
        if (poll_pend) ovr <= 1'b1;
      end else if (grant_poll) begin
        poll_pend <= 1'b0;
      end
      if (!bus.host_req || grant_host) starve_cnt <= 8'h00;
      else if (grant_poll)             starve_cnt <= starve_cnt + 8'h01;
    end
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      host_ack   <= 1'b0;
      host_rdata <= 16'h0000;
      aux_a      <= 16'h0000;
      aux_b      <= 16'h0000;
      sample_vld <= 1'b0;
    end else begin
      host_ack   <= 1'b0;
      sample_vld <= 1'b0;
      if (drp_done || drp_abort) begin
        if (cur_host) begin
          host_ack   <= 1'b1;
          host_rdata <= (drp_done && !cur_we) ? bus.dout : 16'h0000;
        end else if (drp_done && cur_addr == AUX_A_ADDR) begin
          aux_a      <= bus.dout;
          sample_vld <= 1'b1;
        end else if (drp_done && cur_addr == AUX_B_ADDR) begin
          aux_b      <= bus.dout;
          sample_vld <= 1'b1;
        end
      end
    end
  end

`ifdef XADC_DRP_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] to_cnt;
  logic       host_err;

  // Loaded to 1 in ISSUE so the abort lands exactly TIMEOUT_CYC cycles after DEN.
  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n)              to_cnt <= 8'h00;
    else if (state == S_ISSUE) to_cnt <= 8'h01;
    else if (state == S_WAIT)  to_cnt <= to_cnt + 8'h01;
  end

  assign timeout_hit = (to_cnt >= TIMEOUT_LAST);

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n)                  host_err <= 1'b0;
    else if (drp_done && cur_host)  host_err <= 1'b0;
    else if (drp_abort && cur_host) host_err <= 1'b1;
  end

  assign bus.host_err = host_err;
`else
  assign timeout_hit  = 1'b0;
  assign bus.host_err = 1'b0;
`endif

  assign bus.den        = den;
  assign bus.dwe        = dwe;
  assign bus.daddr      = daddr;
  assign bus.di         = di;
  assign bus.host_ack   = host_ack;
  assign bus.host_rdata = host_rdata;
  assign bus.aux_a_data = aux_a;
  assign bus.aux_b_data = aux_b;
  assign bus.sample_vld = sample_vld;
  assign bus.ovr        = ovr;
endmodule

// File: tb/tb_xadc_drp_sched.sv
// tb/tb_xadc_drp_sched.sv - directed and randomized bench for xadc_drp_sched against a transaction-level model
module tb_xadc_drp_sched;
`ifdef XADC_DRP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 64;

  logic dclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 dclk = ~dclk;

  xadc_drp_sched_if bus();
  xadc_drp_sched dut (.dclk(dclk), .reset_n(reset_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // model: pending poll, starvation count, one outstanding transaction
  bit          m_pend, m_ovr;
  logic [6:0]  m_paddr;
  int          m_starve, m_idle_at;
  bit          t_act, t_host, t_we;
  int          t_den;
  logic [6:0]  t_addr;
  bit          e_den, e_ack, e_err, e_svld, e_we;
  logic [6:0]  e_addr;
  logic [15:0] e_di, e_rdata, e_aux_a, e_aux_b;

  // stimulus controls and observation log
  bit          rnd_mode, nxt_eoc, nxt_host, nxt_we, resp_never, resp_do_fixed;
  logic [4:0]  nxt_ch;
  logic [6:0]  nxt_addr;
  logic [15:0] nxt_wdata, resp_do;
  int          resp_delay, r_at;
  int          n_ack, n_svld, n_poll, glog, glen, last_den_k, last_ack_k;
  logic [6:0]  last_daddr, last_paddr;
  logic [15:0] last_di;
  logic        last_dwe, last_err;

  task automatic model_reset();
    m_pend = 0; m_ovr = 0; m_paddr = '0; m_starve = 0; m_idle_at = 0;
    t_act = 0; t_host = 0; t_we = 0; t_den = 0; t_addr = '0;
    e_den = 0; e_ack = 0; e_err = 0; e_svld = 0; e_we = 0;
    e_addr = '0; e_di = '0; e_rdata = '0; e_aux_a = '0; e_aux_b = '0;
  endtask

  task automatic idle_inputs();
    bus.eoc = 0; bus.channel = '0; bus.drdy = 0; bus.dout = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    nxt_eoc = 0; nxt_host = 0; r_at = -1;
  endtask

  task automatic model_step();
    bit req, old_pend, gp, gh, err;
    req = bus.host_req; old_pend = m_pend; gp = 0; gh = 0; err = 0;
    e_den = 0; e_ack = 0; e_err = 0; e_svld = 0;
    if (t_act && k > t_den) begin
      if (bus.drdy || (TO_EN && k == t_den + TO_CYC - 1)) begin
        err = !bus.drdy;
        t_act = 0;
        m_idle_at = k + 2;
        if (t_host) begin
          e_ack = 1; e_err = err;
          e_rdata = (err || t_we) ? 16'h0 : bus.dout;
        end else if (!err && t_addr == 7'h13) begin
          e_aux_a = bus.dout; e_svld = 1;
        end else if (!err && t_addr == 7'h12) begin
          e_aux_b = bus.dout; e_svld = 1;
        end
      end
    end else if (!t_act && k >= m_idle_at) begin
      if (m_pend && !(req && m_starve == 2)) gp = 1;
      else if (req) gh = 1;
      if (gp || gh) begin
        t_act = 1; t_den = k + 1; t_host = gh;
        t_we = gh ? bus.host_we : 1'b0;
        t_addr = gh ? bus.host_addr : m_paddr;
        e_den = 1; e_we = t_we; e_addr = t_addr; e_di = bus.host_wdata;
      end
    end
    if (!req || gh) m_starve = 0;
    else if (gp)    m_starve++;
    if (gp) m_pend = 0;
    if (bus.eoc) begin
      if (old_pend) m_ovr = 1;
      m_pend = 1;
      m_paddr = {2'b00, bus.channel};
    end
  endtask

  task automatic run_cycle();
    bit never;
    @(negedge dclk);
    k++;
    check("den", bus.den, e_den);
    if (e_den) begin
      check("dwe", bus.dwe, e_we);
      check("daddr", bus.daddr, e_addr);
      if (e_we) check("di", bus.di, e_di);
    end
    check("host_ack", bus.host_ack, e_ack);
    if (e_ack) begin
      check("host_err", bus.host_err, e_err);
      check("host_rdata", bus.host_rdata, e_rdata);
    end
    check("sample_vld", bus.sample_vld, e_svld);
    check("aux_a", bus.aux_a_data, e_aux_a);
    check("aux_b", bus.aux_b_data, e_aux_b);
    check("ovr", bus.ovr, m_ovr);
    if (bus.den) begin
      last_den_k = k; last_daddr = bus.daddr; last_di = bus.di; last_dwe = bus.dwe;
      if (glen < 3) begin glog = glog * 2 + ((bus.daddr > 7'h1f) ? 1 : 0); glen++; end
      if (bus.daddr <= 7'h1f && !bus.dwe) begin n_poll++; last_paddr = bus.daddr; end
      never = resp_never || (rnd_mode && TO_EN && $urandom_range(0, 7) == 0);
      r_at = never ? -1 : k + ((resp_delay > 0) ? resp_delay : int'($urandom_range(1, 6)));
    end
    if (bus.host_ack) begin
      n_ack++; last_ack_k = k; last_err = bus.host_err; bus.host_req = 0;
    end
    if (bus.sample_vld) n_svld++;
    bus.drdy = (r_at == k);
    if (rnd_mode && !t_act && $urandom_range(0, 15) == 0) bus.drdy = 1;
    bus.dout = resp_do_fixed ? resp_do : 16'($urandom);
    if (rnd_mode) begin
      if ($urandom_range(0, 7) == 0) begin
        nxt_eoc = 1;
        case ($urandom_range(0, 3))
          0:       nxt_ch = 5'h12;
          1:       nxt_ch = 5'h13;
          default: nxt_ch = 5'($urandom);
        endcase
      end
      if (!bus.host_req && $urandom_range(0, 9) == 0) begin
        nxt_host = 1; nxt_we = 1'($urandom_range(0, 1));
        nxt_addr = 7'h40 + 7'($urandom_range(0, 63)); nxt_wdata = 16'($urandom);
      end
    end
    bus.eoc = nxt_eoc;
    bus.channel = nxt_eoc ? nxt_ch : 5'($urandom);
    nxt_eoc = 0;
    if (nxt_host) begin
      bus.host_req = 1; bus.host_we = nxt_we; bus.host_addr = nxt_addr; bus.host_wdata = nxt_wdata;
      nxt_host = 0;
    end
    model_step();
  endtask

  task automatic apply_reset(input bit late_drdy);
    @(negedge dclk);
    k++;
    reset_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_den", bus.den, 0);
    check("rst_host_ack", bus.host_ack, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    check("rst_host_err", bus.host_err, 0);
    check("rst_aux_a", bus.aux_a_data, 0);
    check("rst_aux_b", bus.aux_b_data, 0);
    check("rst_sample_vld", bus.sample_vld, 0);
    check("rst_ovr", bus.ovr, 0);
    @(negedge dclk);
    k++;
    reset_n = 1;
    bus.drdy = late_drdy;
    bus.dout = 16'hBEEF;
    model_step();
  endtask

  initial begin
    rnd_mode = 0; resp_never = 0; resp_do_fixed = 0; resp_do = '0; resp_delay = 3;
    n_ack = 0; n_svld = 0; n_poll = 0; glog = 0; glen = 3;
    last_den_k = 0; last_ack_k = 0; last_daddr = '0; last_paddr = '0;
    last_di = '0; last_dwe = 0; last_err = 0;
    nxt_ch = '0; nxt_we = 0; nxt_addr = '0; nxt_wdata = '0;
    idle_inputs();
    model_reset();
    apply_reset(1'b0);

    // auto-poll of AUX A
    resp_delay = 3; resp_do_fixed = 1; resp_do = 16'hE3E0;
    nxt_eoc = 1; nxt_ch = 5'h13;
    repeat (12) run_cycle();
    check("t1_aux_a", bus.aux_a_data, 16'hE3E0);
    check("t1_daddr", last_daddr, 7'h13);
    check("t1_dwe", last_dwe, 0);
    check("t1_svld_cnt", n_svld, 1);
    check("t1_no_ack", n_ack, 0);

    // host write
    resp_do_fixed = 0; n_ack = 0;
    nxt_host = 1; nxt_we = 1; nxt_addr = 7'h41; nxt_wdata = 16'h2000;
    repeat (10) run_cycle();
    check("t2_dwe", last_dwe, 1);
    check("t2_daddr", last_daddr, 7'h41);
    check("t2_di", last_di, 16'h2000);
    check("t2_ack_cnt", n_ack, 1);
    check("t2_err", last_err, 0);

    // host starvation bound
    glog = 0; glen = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin nxt_eoc = 1; nxt_ch = 5'h05; end
      if (i == 1) begin nxt_host = 1; nxt_we = 0; nxt_addr = 7'h41; nxt_wdata = 16'h0; end
      run_cycle();
    end
    repeat (10) run_cycle();
    check("t3_grants", glen, 3);
    check("t3_order_pph", glog, 1);

    // overrun: two EOCs while host owns the port
    resp_delay = 6; n_poll = 0;
    nxt_host = 1; nxt_we = 0; nxt_addr = 7'h41;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin nxt_eoc = 1; nxt_ch = 5'h12; end
      if (i == 5) begin nxt_eoc = 1; nxt_ch = 5'h13; end
      run_cycle();
    end
    check("t4_ovr", bus.ovr, 1);
    check("t4_poll_cnt", n_poll, 1);
    check("t4_poll_addr", last_paddr, 7'h13);

`ifdef XADC_DRP_TIMEOUT_EN
    resp_never = 1; n_ack = 0;
    nxt_host = 1; nxt_we = 0; nxt_addr = 7'h42;
    repeat (80) run_cycle();
    check("t5_ack_cnt", n_ack, 1);
    check("t5_err", last_err, 1);
    check("t5_latency", last_ack_k - last_den_k, TO_CYC);
    resp_never = 0;
`endif

    // reset during WAIT with a late DRDY
    resp_delay = 5;
    nxt_host = 1; nxt_we = 0; nxt_addr = 7'h41;
    repeat (3) run_cycle();
    apply_reset(1'b1);
    n_ack = 0; n_svld = 0;
    repeat (10) run_cycle();
    check("t6_no_ack", n_ack, 0);
    check("t6_no_svld", n_svld, 0);

    // randomized traffic
    resp_delay = 0; rnd_mode = 1;
    repeat (4000) run_cycle();
    rnd_mode = 0;
    repeat (150) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
